// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier around an N-bit ripple-carry adder: N accumulate/shift
// iterations per operation, unsigned or two's-complement selected per operation.

module seq_mul_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_mul_rca #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    seq_mul_fa u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[W];
endmodule

module seq_mul_unit #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           is_signed,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P,
  output logic           busy
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [N-1:0]    mcand, hi, lo;
  logic            neg;
  logic [CW-1:0]   count;

  logic [N-1:0]    neg_a, neg_b, abs_a, abs_b;
  logic [N-1:0]    addend, sum;
  logic            cout;
  logic [2*N-1:0]  prod, prod_neg;
  logic            unused_co_a, unused_co_b, unused_co_p;

  // Magnitudes through the same adder cell: ~X + 1. -2^(N-1) maps to 2^(N-1) unsigned.
  seq_mul_rca #(.W(N)) u_neg_a (
    .a(~A), .b('0), .cin(1'b1), .sum(neg_a), .cout(unused_co_a)
  );
  seq_mul_rca #(.W(N)) u_neg_b (
    .a(~B), .b('0), .cin(1'b1), .sum(neg_b), .cout(unused_co_b)
  );

  assign abs_a = (is_signed && A[N-1]) ? neg_a : A;
  assign abs_b = (is_signed && B[N-1]) ? neg_b : B;

  // Accumulate step: hi + (lo[0] ? mcand : 0)
  assign addend = lo[0] ? mcand : '0;

  seq_mul_rca #(.W(N)) u_acc (
    .a(hi), .b(addend), .cin(1'b0), .sum(sum), .cout(cout)
  );

  // {cout, sum, lo} >> 1, i.e. the register contents after this iteration's shift
  assign prod = {cout, sum, lo[N-1:1]};

  seq_mul_rca #(.W(2*N)) u_neg_p (
    .a(~prod), .b('0), .cin(1'b1), .sum(prod_neg), .cout(unused_co_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      P         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      count     <= '0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      neg       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= abs_a;
            hi       <= '0;
            lo       <= abs_b;
            neg      <= is_signed & (A[N-1] ^ B[N-1]);
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          hi    <= prod[2*N-1:N];
          lo    <= prod[N-1:0];
          count <= count + CW'(1);
          if (count == CW'(N-1)) begin
            P         <= neg ? prod_neg : prod;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Iterative shift-add multiplier that sits directly around the ALU's N-bit ripple-carry adder: it feeds operands to the adder every cycle and consumes its sum and carry-out.
- Accepts two N-bit operands over a valid/ready handshake, runs N accumulate/shift iterations, and returns a 2N-bit product over a valid/ready handshake.
- Supports unsigned and two's-complement signed operation, selected per operation.

Parameters:
- N, 32, operand width in bits; legal range N >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns the block to IDLE from any state.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- is_signed  input  1  1 = operands are two's complement; sampled with the operands.
- A  input  N  multiplicand.
- B  input  N  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- P  output  2N  product.
- busy  output  1  high in RUN.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, P=0, out_valid=0, busy=0, in_ready=1, iteration count=0, internal accumulator=0.
- States: IDLE, RUN, DONE. in_ready is 1 only in IDLE; out_valid is 1 only in DONE; busy is 1 only in RUN.
- IDLE:
  - On in_valid & in_ready, latch the operands:
    - mcand = |A| if is_signed, else A.
    - hi = 0.
    - lo = |B| if is_signed, else B.
    - neg = is_signed & (A[N-1] ^ B[N-1]).
    - count = 0.
  - Then go to RUN. Otherwise stay in IDLE.
- Magnitude: |X| = two's-complement negation when X[N-1]=1, interpreted as N-bit unsigned. For X = -2^(N-1), |X| = 2^(N-1); no overflow.
- RUN, one iteration per cycle:
  - If lo[0]=1, the adder computes hi + mcand with carry-in 0; otherwise the addend is 0.
  - The adder instance is the team's N-bit ripple-carry adder.
  - Shift {Cout, sum, lo} right by 1 into {hi, lo}; count increments.
- Termination:
  - On the iteration where count = N-1, load P with {hi, lo} after the shift.
  - P is negated in 2N bits (invert plus one, using a 2N-bit instance of the same adder with carry-in 1) when neg=1.
  - Set out_valid=1 and go to DONE.
- Latency:
  - Acceptance edge E0; iterations at E1..EN; out_valid is high after EN.
  - Latency is exactly N cycles for all operand values. There is no early exit on zero.
- DONE:
  - P and out_valid hold stable until out_valid & out_ready.
  - On that edge, out_valid goes to 0 and the state goes to IDLE; the next accept is possible on the following edge.
  - in_valid is ignored in DONE and RUN.
- flush:
  - Highest priority among synchronous events.
  - Next state is IDLE; out_valid=0 and busy=0; P is unchanged.
  - A simultaneous in_valid is not accepted.
- Reset mid-operation: immediate return to the reset values regardless of state. No partial product is ever presented.
- Operand stability: A, B and is_signed are sampled only at acceptance; later changes have no effect.
- Unsigned result: exact 2N-bit product, maximum (2^N-1)^2.
- Signed result: exact 2N-bit two's-complement product. (-2^(N-1))^2 = 2^(2N-2) is representable.
- Timing: no combinational path from in_valid or out_ready to any output.

Test Plan:
- N=8, unsigned, A=0xFF, B=0xFF -> P=0xFE01 with out_valid high exactly 8 cycles after acceptance; busy high for 8 cycles.
- N=8, signed, A=0xFD (-3), B=0x07 -> P=0xFFEB (-21); then A=0x80, B=0x80 -> P=0x4000; then A=0x80, B=0x01 -> P=0xFF80.
- N=32, unsigned, A=0xFFFFFFFF, B=2 -> P=0x1_FFFFFFFE; then A=0, B=0x12345678 -> P=0 with the same 32-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> P and out_valid stable, in_ready=0, a pulsed in_valid is ignored. Release out_ready -> IDLE next cycle; the next operation's result is correct.
- flush asserted in RUN at iteration 3 with in_valid=1 -> IDLE next edge, no out_valid, previous P retained, in_ready=1. A following 5×6 unsigned operation returns P=30.
- rst_n deasserted low asynchronously mid-RUN (between edges) -> all outputs reach reset values immediately. After release, an unsigned 12×12 operation returns P=144 in N cycles.
